// File: rtl/switch_debouncer.sv
// Switch debouncer: synchronises a raw, bouncing switch level and only
// changes the clean level after a run of identical samples. Also produces
// one-cycle edge pulses and a saturating count of aborted settle periods.
module switch_debouncer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned CNT_W         = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sw_in,
  input  logic       bounce_clr,
  output logic       sw_db,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       busy,
  output logic [7:0] bounce_cnt
);

  localparam int unsigned BW = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [BW-1:0]    BNC_MAX  = {BW{1'b1}};

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sw_db_q, sw_db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic [BW-1:0]    bounce_q, bounce_d;
  logic             abort;

  // Synchroniser chain; only its last stage feeds the FSM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // State, counter and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      sw_db_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      busy_q   <= 1'b0;
      bounce_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_db_q  <= sw_db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      bounce_q <= bounce_d;
    end
  end

  // Next-state: start counting on a level change, commit after a full stable run.
  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    sw_db_d  = sw_db_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    abort    = 1'b0;
    bounce_d = bounce_q;

    unique case (state_q)
      IDLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = IDLE_LOW;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HIGH;
          sw_db_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      IDLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = IDLE_HIGH;
          abort   = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LOW;
          sw_db_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE_LOW;
      end
    endcase

    // Clear wins over a same-cycle abort; the count saturates rather than wraps.
    if (bounce_clr) begin
      bounce_d = '0;
    end else if (abort && (bounce_q != BNC_MAX)) begin
      bounce_d = bounce_q + BW'(1);
    end

    busy_d = (state_d == WAIT_HIGH) || (state_d == WAIT_LOW);
  end

  assign sw_db      = sw_db_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign busy       = busy_q;
  assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with a pulse scoreboard.
module tb_switch_debouncer;

  logic       clock;
  logic       reset_n;
  logic       sw_in;
  logic       bounce_clr;
  logic       sw_db;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       busy;
  logic [7:0] bounce_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;

  typedef struct {
    logic        is_rise;
    int unsigned cyc;
  } ev_t;

  ev_t sb_q[$];

  switch_debouncer #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sw_in     (sw_in),
    .bounce_clr(bounce_clr),
    .sw_db     (sw_db),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .busy      (busy),
    .bounce_cnt(bounce_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Expect a pulse 6 edges after the current drive point (2 sync + 4 stable).
  task automatic expect_pulse(input logic is_rise);
    ev_t e;
    e.is_rise = is_rise;
    e.cyc     = cyc + 6;
    sb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sw_db"}, 32'(sw_db), 32'd0);
    chk({tag, "_rise"},  32'(rise_pulse), 32'd0);
    chk({tag, "_fall"},  32'(fall_pulse), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_bcnt"},  32'(bounce_cnt), 32'd0);
  endtask

  // Every observed pulse must match the next scheduled one in kind and cycle.
  always @(negedge clock) begin
    if (rise_pulse || fall_pulse) begin
      ev_t e;
      chk("pulse_excl", 32'(rise_pulse & fall_pulse), 32'd0);
      n_cmp++;
      assert (sb_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_pulse: observed rise=%0b fall=%0b at cycle %0d expected none",
               rise_pulse, fall_pulse, cyc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pulse_kind",  32'(rise_pulse), 32'(e.is_rise));
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $error("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    sw_in      = 1'b0;
    bounce_clr = 1'b0;
    #23;
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Idle low for 10 clocks.
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk_all_zero("idle");
    end

    // Clean press.
    sw_in = 1'b1;
    expect_pulse(1'b1);
    tick(3);
    chk("press_busy_e3", 32'(busy), 32'd1);
    chk("press_db_e3", 32'(sw_db), 32'd0);
    tick(2);
    chk("press_db_e5", 32'(sw_db), 32'd0);
    chk("press_busy_e5", 32'(busy), 32'd1);
    tick(1);
    chk("press_db_e6", 32'(sw_db), 32'd1);
    chk("press_rise_e6", 32'(rise_pulse), 32'd1);
    chk("press_busy_e6", 32'(busy), 32'd0);
    tick(1);
    chk("press_rise_e7", 32'(rise_pulse), 32'd0);
    chk("press_db_e7", 32'(sw_db), 32'd1);
    tick(3);

    // Clean release.
    sw_in = 1'b0;
    expect_pulse(1'b0);
    tick(5);
    chk("rel_db_e5", 32'(sw_db), 32'd1);
    tick(1);
    chk("rel_db_e6", 32'(sw_db), 32'd0);
    chk("rel_fall_e6", 32'(fall_pulse), 32'd1);
    chk("rel_rise_e6", 32'(rise_pulse), 32'd0);
    tick(1);
    chk("rel_fall_e7", 32'(fall_pulse), 32'd0);
    chk("rel_bcnt", 32'(bounce_cnt), 32'd0);
    tick(3);

    // Bouncy press: 1,0,1,0 for 2 clocks each, then settle at 1.
    for (int i = 0; i < 2; i++) begin
      sw_in = 1'b1;
      tick(2);
      sw_in = 1'b0;
      tick(2);
    end
    sw_in = 1'b1;
    expect_pulse(1'b1);
    tick(5);
    chk("bounce_db_e5", 32'(sw_db), 32'd0);
    tick(1);
    chk("bounce_db_e6", 32'(sw_db), 32'd1);
    chk("bounce_rise_e6", 32'(rise_pulse), 32'd1);
    chk("bounce_bcnt", 32'(bounce_cnt), 32'd2);
    tick(3);

    // One-clock low glitch: no fall, one more abort.
    sw_in = 1'b0;
    tick(1);
    sw_in = 1'b1;
    tick(8);
    chk("glitch_db", 32'(sw_db), 32'd1);
    chk("glitch_bcnt", 32'(bounce_cnt), 32'd3);

    // 300 glitches saturate the bounce count.
    for (int i = 0; i < 300; i++) begin
      sw_in = 1'b0;
      tick(1);
      sw_in = 1'b1;
      tick(1);
    end
    tick(10);
    chk("sat_bcnt", 32'(bounce_cnt), 32'd255);
    chk("sat_db", 32'(sw_db), 32'd1);
    tick(10);
    chk("sat_hold", 32'(bounce_cnt), 32'd255);

    // Clear coinciding with an abort edge.
    sw_in = 1'b0;
    tick(1);
    sw_in = 1'b1;
    tick(2);
    chk("clr_busy", 32'(busy), 32'd1);
    bounce_clr = 1'b1;
    tick(1);
    bounce_clr = 1'b0;
    chk("clr_bcnt", 32'(bounce_cnt), 32'd0);
    chk("clr_idle", 32'(busy), 32'd0);
    tick(5);
    chk("clr_hold", 32'(bounce_cnt), 32'd0);

    // Asynchronous reset in the middle of a release wait.
    sw_in = 1'b0;
    tick(3);
    chk("rstw_busy", 32'(busy), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all_zero("rstw");
    sw_in = 1'b1;
    tick(2);
    chk_all_zero("rstw_hold");
    reset_n = 1'b1;
    expect_pulse(1'b1);
    tick(5);
    chk("rstw_db_e5", 32'(sw_db), 32'd0);
    tick(1);
    chk("rstw_db_e6", 32'(sw_db), 32'd1);
    chk("rstw_rise_e6", 32'(rise_pulse), 32'd1);
    chk("rstw_bcnt", 32'(bounce_cnt), 32'd0);
    tick(5);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
